// File: rtl/ascii_to_scan_seq.sv
// Keystroke sequencer: one ASCII character in, PS/2 Set-2 make/break bytes out on a valid/ready stream.
// Define SHIFT_SEQ_EN to wrap shifted characters in LShift make (12) and break (F0 12).
module ascii_to_scan_seq #(
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic       clk50,
    input  logic       reset,
    input  logic       ascii_vld,
    input  logic [7:0] ascii_data,
    output logic       ascii_rdy,
    output logic       scan_vld,
    output logic [7:0] scan_data,
    input  logic       scan_rdy,
    output logic       err
);

    localparam logic [7:0] GAP_LOAD     = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
    localparam logic [7:0] BREAK_PREFIX = 8'hF0;

`ifdef SHIFT_SEQ_EN
    localparam logic [7:0] LSHIFT_CODE = 8'h12;

    typedef enum logic [2:0] {
        IDLE, SH_MK, KEY_MK, BRK_F0, KEY_BRK, SH_F0, SH_BRK, GAP
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE, KEY_MK, BRK_F0, KEY_BRK, GAP
    } state_t;
`endif

    state_t     state, state_next;
    state_t     resume, resume_next;
    state_t     after_byte;
    logic [7:0] gap_cnt, gap_cnt_next;
    logic [7:0] key_code;
    logic [7:0] folded;
    logic [7:0] lk_code;
    logic       lk_mapped;
    logic       accept;
`ifdef SHIFT_SEQ_EN
    logic       key_shift;
    logic       lk_shift;
`endif

    assign ascii_rdy = reset & (state == IDLE);
    assign accept    = ascii_vld & ascii_rdy;

    // Lower-case letters share the upper-case key code, so fold them first.
    always_comb begin
        folded = ascii_data;
        if (ascii_data >= 8'h61 && ascii_data <= 8'h7A)
            folded = ascii_data - 8'h20;
        lk_mapped = 1'b1;
        lk_code   = 8'h00;
        case (folded)
            8'h30: lk_code = 8'h45;
            8'h31: lk_code = 8'h16;
            8'h32: lk_code = 8'h1E;
            8'h33: lk_code = 8'h26;
            8'h34: lk_code = 8'h25;
            8'h35: lk_code = 8'h2E;
            8'h36: lk_code = 8'h36;
            8'h37: lk_code = 8'h3D;
            8'h38: lk_code = 8'h3E;
            8'h39: lk_code = 8'h46;
            8'h41: lk_code = 8'h1C;
            8'h42: lk_code = 8'h32;
            8'h43: lk_code = 8'h21;
            8'h44: lk_code = 8'h23;
            8'h45: lk_code = 8'h24;
            8'h46: lk_code = 8'h2B;
            8'h47: lk_code = 8'h34;
            8'h48: lk_code = 8'h33;
            8'h49: lk_code = 8'h43;
            8'h4A: lk_code = 8'h3B;
            8'h4B: lk_code = 8'h42;
            8'h4C: lk_code = 8'h4B;
            8'h4D: lk_code = 8'h3A;
            8'h4E: lk_code = 8'h31;
            8'h4F: lk_code = 8'h44;
            8'h50: lk_code = 8'h4D;
            8'h51: lk_code = 8'h15;
            8'h52: lk_code = 8'h2D;
            8'h53: lk_code = 8'h1B;
            8'h54: lk_code = 8'h2C;
            8'h55: lk_code = 8'h3C;
            8'h56: lk_code = 8'h2A;
            8'h57: lk_code = 8'h1D;
            8'h58: lk_code = 8'h22;
            8'h59: lk_code = 8'h35;
            8'h5A: lk_code = 8'h1A;
            8'h20: lk_code = 8'h29;
            8'h0D: lk_code = 8'h5A;
            8'h08: lk_code = 8'h66;
            8'h09: lk_code = 8'h0D;
            8'h7E: lk_code = 8'h0E;
            8'h5F: lk_code = 8'h4E;
            8'h2B: lk_code = 8'h55;
            8'h7B: lk_code = 8'h54;
            8'h7D: lk_code = 8'h5B;
            8'h7C: lk_code = 8'h5D;
            8'h3A: lk_code = 8'h4C;
            8'h22: lk_code = 8'h52;
            8'h3C: lk_code = 8'h41;
            8'h3E: lk_code = 8'h49;
            8'h3F: lk_code = 8'h4A;
            default: lk_mapped = 1'b0;
        endcase
    end

`ifdef SHIFT_SEQ_EN
    always_comb begin
        case (ascii_data)
            8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C,
            8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F: lk_shift = 1'b1;
            default:                          lk_shift = 1'b0;
        endcase
    end
`endif

    always_ff @(posedge clk50) begin
        if (!reset) begin
            state    <= IDLE;
            resume   <= IDLE;
            gap_cnt  <= 8'd0;
            key_code <= 8'd0;
            err      <= 1'b0;
`ifdef SHIFT_SEQ_EN
            key_shift <= 1'b0;
`endif
        end else begin
            state   <= state_next;
            resume  <= resume_next;
            gap_cnt <= gap_cnt_next;
            err     <= accept & ~lk_mapped;
            if (accept && lk_mapped) begin
                key_code <= lk_code;
`ifdef SHIFT_SEQ_EN
                key_shift <= lk_shift;
`endif
            end
        end
    end

    // Each byte state names its successor; a handshake either jumps there or parks in GAP first.
    always_comb begin
        state_next   = state;
        resume_next  = resume;
        gap_cnt_next = gap_cnt;
        after_byte   = IDLE;
        scan_vld     = 1'b0;
        scan_data    = 8'h00;
        case (state)
            IDLE: begin
                if (accept && lk_mapped) begin
`ifdef SHIFT_SEQ_EN
                    state_next = lk_shift ? SH_MK : KEY_MK;
`else
                    state_next = KEY_MK;
`endif
                end
            end
`ifdef SHIFT_SEQ_EN
            SH_MK: begin
                scan_vld   = 1'b1;
                scan_data  = LSHIFT_CODE;
                after_byte = KEY_MK;
            end
`endif
            KEY_MK: begin
                scan_vld   = 1'b1;
                scan_data  = key_code;
                after_byte = BRK_F0;
            end
            BRK_F0: begin
                scan_vld   = 1'b1;
                scan_data  = BREAK_PREFIX;
                after_byte = KEY_BRK;
            end
            KEY_BRK: begin
                scan_vld   = 1'b1;
                scan_data  = key_code;
`ifdef SHIFT_SEQ_EN
                after_byte = key_shift ? SH_F0 : IDLE;
`else
                after_byte = IDLE;
`endif
            end
`ifdef SHIFT_SEQ_EN
            SH_F0: begin
                scan_vld   = 1'b1;
                scan_data  = BREAK_PREFIX;
                after_byte = SH_BRK;
            end
            SH_BRK: begin
                scan_vld   = 1'b1;
                scan_data  = LSHIFT_CODE;
                after_byte = IDLE;
            end
`endif
            GAP: begin
                if (gap_cnt == 8'd0)
                    state_next = resume;
                else
                    gap_cnt_next = gap_cnt - 8'd1;
            end
            default: state_next = IDLE;
        endcase

        if (scan_vld && scan_rdy) begin
            if (GAP_CYCLES > 0) begin
                state_next   = GAP;
                resume_next  = after_byte;
                gap_cnt_next = GAP_LOAD;
            end else begin
                state_next = after_byte;
            end
        end
    end

endmodule

// File: tb/tb_ascii_to_scan_seq.sv
// Self-checking bench for ascii_to_scan_seq: one instance with no gap, one with a 3-cycle gap,
// both checked against a table-driven model of the expected Set-2 byte streams.
module tb_ascii_to_scan_seq;

    localparam int GAP0 = 0;
    localparam int GAP1 = 3;
`ifdef SHIFT_SEQ_EN
    localparam bit SHIFT_EN = 1'b1;
`else
    localparam bit SHIFT_EN = 1'b0;
`endif

    logic            clk50 = 1'b0;
    logic [1:0]      reset;
    logic [1:0]      ascii_vld;
    logic [1:0][7:0] ascii_data;
    logic [1:0]      ascii_rdy;
    logic [1:0]      scan_vld;
    logic [1:0][7:0] scan_data;
    logic [1:0]      scan_rdy;
    logic [1:0]      err;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] map_key [256];
    bit         map_ok  [256];
    bit         map_shf [256];
    logic [7:0] mapped_list [$];
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q1 [$];

    int         seq_pos    [2];
    int         low_cnt    [2];
    int         hs_count   [2];
    bit         prev_stall [2];
    logic [7:0] prev_data  [2];
    bit         rand_bp    [2];

    logic [7:0] digit_codes  [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] letter_codes [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                                      8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                                      8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
    logic [7:0] shf_chars [11] = '{8'h7E, 8'h5F, 8'h2B, 8'h7B, 8'h7D, 8'h7C, 8'h3A, 8'h22, 8'h3C, 8'h3E, 8'h3F};
    logic [7:0] shf_codes [11] = '{8'h0E, 8'h4E, 8'h55, 8'h54, 8'h5B, 8'h5D, 8'h4C, 8'h52, 8'h41, 8'h49, 8'h4A};

    always #10 clk50 = ~clk50;

    ascii_to_scan_seq #(.GAP_CYCLES(GAP0)) dut_g0 (
        .clk50      (clk50),
        .reset      (reset[0]),
        .ascii_vld  (ascii_vld[0]),
        .ascii_data (ascii_data[0]),
        .ascii_rdy  (ascii_rdy[0]),
        .scan_vld   (scan_vld[0]),
        .scan_data  (scan_data[0]),
        .scan_rdy   (scan_rdy[0]),
        .err        (err[0])
    );

    ascii_to_scan_seq #(.GAP_CYCLES(GAP1)) dut_g3 (
        .clk50      (clk50),
        .reset      (reset[1]),
        .ascii_vld  (ascii_vld[1]),
        .ascii_data (ascii_data[1]),
        .ascii_rdy  (ascii_rdy[1]),
        .scan_vld   (scan_vld[1]),
        .scan_data  (scan_data[1]),
        .scan_rdy   (scan_rdy[1]),
        .err        (err[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int gap_of(input int d);
        return (d == 0) ? GAP0 : GAP1;
    endfunction

    function automatic void set_map(input logic [7:0] c, input logic [7:0] k, input bit s);
        map_key[c] = k;
        map_ok[c]  = 1'b1;
        map_shf[c] = s;
        mapped_list.push_back(c);
    endfunction

    function automatic void init_model();
        for (int i = 0; i < 256; i++) begin
            map_key[i] = 8'h00;
            map_ok[i]  = 1'b0;
            map_shf[i] = 1'b0;
        end
        for (int i = 0; i < 10; i++) set_map(8'(8'h30 + i), digit_codes[i], 1'b0);
        for (int i = 0; i < 26; i++) begin
            set_map(8'(8'h41 + i), letter_codes[i], 1'b0);
            set_map(8'(8'h61 + i), letter_codes[i], 1'b0);
        end
        set_map(8'h20, 8'h29, 1'b0);
        set_map(8'h0D, 8'h5A, 1'b0);
        set_map(8'h08, 8'h66, 1'b0);
        set_map(8'h09, 8'h0D, 1'b0);
        for (int i = 0; i < 11; i++) set_map(shf_chars[i], shf_codes[i], 1'b1);
    endfunction

    function automatic void q_push(input int d, input logic [7:0] b);
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endfunction

    function automatic logic [7:0] q_pop(input int d);
        if (d == 0) return exp_q0.pop_front();
        return exp_q1.pop_front();
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic void q_flush(input int d);
        if (d == 0) exp_q0.delete();
        else        exp_q1.delete();
    endfunction

    function automatic int seq_len(input logic [7:0] c);
        return (SHIFT_EN && map_shf[c]) ? 6 : 3;
    endfunction

    function automatic void expect_char(input int d, input logic [7:0] c);
        bit wrap;
        wrap = SHIFT_EN && map_shf[c];
        if (wrap) q_push(d, 8'h12);
        q_push(d, map_key[c]);
        q_push(d, 8'hF0);
        q_push(d, map_key[c]);
        if (wrap) begin
            q_push(d, 8'hF0);
            q_push(d, 8'h12);
        end
    endfunction

    task automatic tick(input int d);
        @(posedge clk50);
        #1;
        if (rand_bp[d]) scan_rdy[d] = 1'($urandom_range(0, 1));
    endtask

    // Offer one character, hold it until accepted, then optionally wait for the sequence to drain.
    task automatic applyStimulus(input int d, input logic [7:0] c, input int stall, input bit wait_done);
        int cyc;
        int n;
        n = seq_len(c);
        if (stall > 0) scan_rdy[d] = 1'b0;
        ascii_vld[d]  = 1'b1;
        ascii_data[d] = c;
        cyc = 0;
        while (!ascii_rdy[d] && cyc < 400) begin
            tick(d);
            cyc++;
        end
        checkOutput("accept_wait", 32'(cyc < 400), 32'd1);
        tick(d);
        ascii_vld[d] = 1'b0;
        if (map_ok[c]) expect_char(d, c);
        seq_pos[d] = 0;
        checkOutput("err_pulse", 32'(err[d]), 32'(!map_ok[c]));
        checkOutput("rdy_after_accept", 32'(ascii_rdy[d]), 32'(!map_ok[c]));
        if (!map_ok[c]) begin
            checkOutput("no_vld_unmapped", 32'(scan_vld[d]), 32'd0);
            tick(d);
            checkOutput("err_clear", 32'(err[d]), 32'd0);
        end else begin
            checkOutput("first_vld", 32'(scan_vld[d]), 32'd1);
            if (wait_done) begin
                cyc = 0;
                do begin
                    tick(d);
                    cyc++;
                    if (stall > 0 && cyc == stall) scan_rdy[d] = 1'b1;
                end while (!ascii_rdy[d] && cyc < 400);
                if (rand_bp[d]) checkOutput("drain_timeout", 32'(cyc < 400), 32'd1);
                else            checkOutput("busy_cycles", 32'(cyc), 32'(n * (gap_of(d) + 1) + stall));
            end
        end
    endtask

    // Byte-stream monitor: order of bytes, hold-under-backpressure and idle gap length.
    always @(negedge clk50) begin
        logic [7:0] exp_b;
        for (int d = 0; d < 2; d++) begin
            if (!reset[d]) begin
                prev_stall[d] = 1'b0;
                low_cnt[d]    = 0;
            end else begin
                if (prev_stall[d]) begin
                    checkOutput("hold_vld", 32'(scan_vld[d]), 32'd1);
                    checkOutput("hold_data", 32'(scan_data[d]), 32'(prev_data[d]));
                end
                if (scan_vld[d] && scan_rdy[d]) begin
                    if (seq_pos[d] > 0) checkOutput("gap_len", 32'(low_cnt[d]), 32'(gap_of(d)));
                    checkOutput("byte_expected", 32'(q_size(d) != 0), 32'd1);
                    if (q_size(d) != 0) begin
                        exp_b = q_pop(d);
                        checkOutput("scan_byte", 32'(scan_data[d]), 32'(exp_b));
                    end
                    seq_pos[d]++;
                    hs_count[d]++;
                    low_cnt[d] = 0;
                end else if (!scan_vld[d]) begin
                    low_cnt[d]++;
                end
                prev_stall[d] = scan_vld[d] && !scan_rdy[d];
                prev_data[d]  = scan_data[d];
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: time limit reached");
        $fatal(1);
    end

    initial begin
        int cyc;
        int base;
        logic [7:0] c;

        init_model();
        for (int d = 0; d < 2; d++) begin
            seq_pos[d]  = 0;
            low_cnt[d]  = 0;
            hs_count[d] = 0;
            rand_bp[d]  = 1'b0;
        end
        reset      = 2'b00;
        ascii_vld  = 2'b00;
        ascii_data = '0;
        scan_rdy   = 2'b11;

        for (int i = 0; i < 3; i++) tick(0);
        for (int d = 0; d < 2; d++) begin
            checkOutput("rst_ascii_rdy", 32'(ascii_rdy[d]), 32'd0);
            checkOutput("rst_scan_vld", 32'(scan_vld[d]), 32'd0);
            checkOutput("rst_err", 32'(err[d]), 32'd0);
        end
        reset = 2'b11;
        tick(0);
        for (int d = 0; d < 2; d++) begin
            checkOutput("post_rst_rdy", 32'(ascii_rdy[d]), 32'd1);
            checkOutput("post_rst_data", 32'(scan_data[d]), 32'd0);
            checkOutput("post_rst_vld", 32'(scan_vld[d]), 32'd0);
        end

        $display("[TB] directed characters");
        applyStimulus(0, 8'h41, 0, 1);
        applyStimulus(0, 8'h3F, 0, 1);
        applyStimulus(0, 8'h40, 0, 1);
        applyStimulus(0, 8'h31, 0, 1);
        applyStimulus(1, 8'h35, 5, 1);
        applyStimulus(1, 8'h7E, 0, 1);

        $display("[TB] held request while busy");
        applyStimulus(0, 8'h48, 0, 0);
        applyStimulus(0, 8'h69, 0, 1);
        applyStimulus(1, 8'h51, 0, 0);
        applyStimulus(1, 8'h22, 0, 1);

        $display("[TB] reset in mid-sequence");
        base = hs_count[0];
        applyStimulus(0, 8'h7E, 0, 0);
        cyc = 0;
        while (hs_count[0] < base + 2 && cyc < 50) begin
            tick(0);
            cyc++;
        end
        checkOutput("two_bytes_wait", 32'(cyc < 50), 32'd1);
        reset[0]    = 1'b0;
        scan_rdy[0] = 1'b0;
        q_flush(0);
        for (int i = 0; i < 3; i++) tick(0);
        checkOutput("abort_scan_vld", 32'(scan_vld[0]), 32'd0);
        checkOutput("abort_ascii_rdy", 32'(ascii_rdy[0]), 32'd0);
        reset[0]    = 1'b1;
        scan_rdy[0] = 1'b1;
        tick(0);
        applyStimulus(0, 8'h61, 0, 1);

        $display("[TB] random characters with backpressure");
        for (int d = 0; d < 2; d++) begin
            rand_bp[d] = 1'b1;
            for (int i = 0; i < 25; i++) begin
                if ($urandom_range(0, 3) == 0) c = 8'($urandom_range(0, 255));
                else c = mapped_list[$urandom_range(0, mapped_list.size() - 1)];
                applyStimulus(d, c, 0, 1);
            end
            rand_bp[d]  = 1'b0;
            scan_rdy[d] = 1'b1;
        end

        for (int i = 0; i < 4; i++) tick(0);
        checkOutput("leftover_g0", 32'(q_size(0)), 32'd0);
        checkOutput("leftover_g3", 32'(q_size(1)), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ascii_to_scan_seq.md
# ascii_to_scan_seq

Keystroke sequencer for the typewriter datapath: the reverse of the scan-code-to-ASCII translator. It accepts one ASCII character per handshake and emits the matching PS/2 Set-2 make/break byte sequence on a valid/ready byte stream. It feeds the PS/2 host-side transmitter and the scan-code loopback path used for keyboard-less testing.

## Interface
- GAP_CYCLES, 0, idle cycles inserted after every accepted output byte before the next byte or before returning to IDLE (0..255)
- clk50  input  1  system clock, 50 MHz
- reset  input  1  synchronous, active-low
- ascii_vld  input  1  ascii_data valid
- ascii_data  input  8  ASCII character
- ascii_rdy  output  1  block can accept a character (high only in IDLE and reset deasserted)
- scan_vld  output  1  scan_data valid; held until scan_rdy
- scan_data  output  8  Set-2 byte; stable while scan_vld high
- scan_rdy  input  1  downstream accepts byte
- err  output  1  one-cycle pulse: the accepted character has no mapping

## Operation
- Lookup (combinational, applied on accept) gives key code K and a shift flag:
  - Digits 0x30..0x39: 45,16,1E,26,25,2E,36,3D,3E,46.
  - Letters 0x41..0x5A and 0x61..0x7A map to the same code (A=1C … Z=1A, Set-2 standard), unshifted.
  - Space 0x20=29, CR 0x0D=5A, BS 0x08=66, TAB 0x09=0D; all unshifted.
  - Shifted: ~=0E, _=4E, +=55, {=54, }=5B, |=5D, :=4C, "=52, <=41, >=49, ?=4A.
  - Anything else is unmapped.
- Accept: ascii_vld & ascii_rdy. K and shift are latched. For an unmapped character, err pulses and the FSM stays in IDLE; no bytes are emitted.
- Sequence for unshifted characters: K, F0, K.
- Sequence for shifted characters (see Configuration): 12, K, F0, K, F0, 12.
- FSM states: IDLE → SH_MK → KEY_MK → BRK_F0 → KEY_BRK → SH_F0 → SH_BRK → IDLE.
  - Shift states are skipped when shift=0.
  - Each byte state advances on scan_vld & scan_rdy, passing through GAP when GAP_CYCLES>0.
- GAP: scan_vld is low. An 8-bit down-counter is loaded with GAP_CYCLES-1. The FSM resumes the saved next state when the counter reaches 0.
- Reset values: ascii_rdy=0 while reset low. After reset: scan_vld=0, scan_data=00, err=0, state=IDLE, gap counter=0.
- Reset asserted mid-sequence aborts immediately. Remaining break codes are not emitted, and scan_vld=0 after that edge.

## Timing
- Character accepted at edge N: first byte appears with scan_vld=1 after edge N, and ascii_rdy=0 after edge N. For an unmapped character, err=1 for the single cycle after edge N and ascii_rdy stays 1.
- Byte handshake at edge M, GAP_CYCLES=0: next byte is valid after edge M, giving back-to-back throughput of one byte per cycle.
- Byte handshake at edge M, GAP_CYCLES=G>0: scan_vld is low for G cycles; the next byte is valid after edge M+G.
- Last byte handshake at edge M: ascii_rdy=1 after edge M+G. A new character can be accepted at edge M+G+1.
- scan_rdy held low: scan_vld and scan_data are held indefinitely. scan_rdy while scan_vld=0 is ignored.
- ascii_vld while busy: ignored and not captured. Upstream holds ascii_vld and ascii_data until ascii_rdy.
- Minimum character period with G=0: 4 cycles unshifted, 7 cycles shifted.

## Configuration
- SHIFT_SEQ_EN defined: shifted characters are wrapped in LShift make (12) and break (F0 12), giving 6 bytes.
- SHIFT_SEQ_EN undefined: the shift flag is ignored and every mapped character emits 3 bytes (K, F0, K). The SH_MK, SH_F0 and SH_BRK states are not built.

## Test plan
- 'A' (0x41), scan_rdy=1, G=0 → scan bytes 1C, F0, 1C on three consecutive cycles; ascii_rdy high again the cycle after the third byte.
- '?' (0x3F) with SHIFT_SEQ_EN → 12, 4A, F0, 4A, F0, 12. Without SHIFT_SEQ_EN → 4A, F0, 4A.
- 0x40 '@' (unmapped) → err one cycle, no scan_vld, ascii_rdy stays 1; a following '1' then yields 16, F0, 16.
- G=3, '5' (0x35), scan_rdy stalled low 5 cycles on the first byte → 2E held stable for the stall; then exactly 3 idle cycles between 2E, F0 and 2E.
- Reset pulled low after the second byte of '~' → no further bytes, scan_vld=0, ascii_rdy=0 during reset; after release, 'a' (0x61) yields 1C, F0, 1C.
- ascii_vld held with a new character during a sequence → not accepted until ascii_rdy; each character produces exactly one sequence.
